tstate_seq: RTL



---
 rtl/tstate_seq.sv | 85 ++++++++
 1 files changed

// File: rtl/tstate_seq.sv
// T-state sequencer: steps the 3-bit T-state index for the timing decoder,
// with free-run, single-step, early end-of-instruction and halt/abort.
module tstate_seq #(
  parameter int ICNT_W = 16
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              run,
  input  logic              step,
  input  logic              halt,
  input  logic              eoi,
  input  logic [2:0]        last_t,
  output logic [2:0]        tcounts,
  output logic              running,
  output logic              instr_done,
  output logic [ICNT_W-1:0] icount
);

  typedef enum logic {ST_STOPPED = 1'b0, ST_RUNNING = 1'b1} state_t;

  state_t            r_state;
  state_t            w_state_nxt;
  logic [2:0]        r_tcounts;
  logic              r_running;
  logic              r_instr_done;
  logic [ICNT_W-1:0] r_icount;

  logic              w_adv;
  logic              w_wrap;

  // Run transitions cost one edge with no advance in either direction;
  // step only counts while stopped with run low.
  always_comb begin
    w_state_nxt = r_state;
    w_adv       = 1'b0;
    case (r_state)
      ST_STOPPED: begin
        if (run)       w_state_nxt = ST_RUNNING;
        else if (step) w_adv       = 1'b1;
      end
      ST_RUNNING: begin
        if (run) w_adv       = 1'b1;
        else     w_state_nxt = ST_STOPPED;
      end
      default: w_state_nxt = ST_STOPPED;
    endcase
  end

  // >= keeps tcounts in range even if last_t drops below the current index.
  assign w_wrap = eoi || (r_tcounts >= last_t);

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state      <= ST_STOPPED;
      r_running    <= 1'b0;
      r_tcounts    <= 3'd0;
      r_instr_done <= 1'b0;
      r_icount     <= '0;
    end else if (halt) begin
      // Aborted instruction is not counted.
      r_state      <= ST_STOPPED;
      r_running    <= 1'b0;
      r_tcounts    <= 3'd0;
      r_instr_done <= 1'b0;
    end else begin
      r_state      <= w_state_nxt;
      r_running    <= (w_state_nxt == ST_RUNNING);
      r_instr_done <= w_adv && w_wrap;
      if (w_adv) begin
        if (w_wrap) begin
          r_tcounts <= 3'd0;
          r_icount  <= r_icount + ICNT_W'(1);
        end else begin
          r_tcounts <= r_tcounts + 3'd1;
        end
      end
    end
  end

  assign tcounts    = r_tcounts;
  assign running    = r_running;
  assign instr_done = r_instr_done;
  assign icount     = r_icount;

endmodule
